instr_fetch: RTL and testbench

Fetch stage for the single-cycle RV32 core: owns the program counter, issues word requests to instruction memory over a request/response handshake, and presents one instruction at a time, with its PC, to the decode/datapath stage. It consumes the branch/jump target and the taken decision from the datapath and control, and selects the next PC. It also reports misaligned targets and keeps a count of consumed instructions.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 94 +++++++++
 tb/tb_instr_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response channel.
// The fetch stage is the master; instruction memory is the slave.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32 fetch stage: PC ownership, one-outstanding imem fetch,
// next-PC select, misaligned-target fault and retire counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCSrc,
  input  logic [31:0]   PCTarget,
  input  logic          stall,
  instr_fetch_if.master imem,
  output logic [31:0]   instr,
  output logic [31:0]   PC,
  output logic [31:0]   PCPlus4,
  output logic          instr_valid,
  output logic          fetch_fault,
  output logic [31:0]   retire_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    VALID,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] next_pc;

  assign next_pc = PCSrc ? PCTarget : pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    retire_d = retire_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem.imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          retire_d = retire_q + 32'd1;
          // A misaligned target freezes PC at the faulting instr.
          if (next_pc[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == VALID);
  assign fetch_fault    = (state_q == FAULT);
  assign instr          = instr_q;
  assign PC             = pc_q;
  assign PCPlus4        = pc_q + 32'd4;
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: event-level reference model plus directed
// scenarios on two instances (RESET_PC = 0 and RESET_PC = FFFF_FFFC).
module tb_instr_fetch;
  localparam logic [31:0] RST1 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pcsrc0, stall0, pcsrc1, stall1;
  logic [31:0] tgt0, tgt1;
  logic [31:0] instr0, pc0, p40, rc0, instr1, pc1, p41, rc1;
  logic        v0, ff0, v1, ff1;

  instr_fetch_if if0();
  instr_fetch_if if1();

  instr_fetch #(.RESET_PC(32'h0)) dut0 (
    .clk(clk), .rst(rst), .PCSrc(pcsrc0), .PCTarget(tgt0),
    .stall(stall0), .imem(if0), .instr(instr0), .PC(pc0),
    .PCPlus4(p40), .instr_valid(v0), .fetch_fault(ff0),
    .retire_count(rc0)
  );

  instr_fetch #(.RESET_PC(RST1)) dut1 (
    .clk(clk), .rst(rst), .PCSrc(pcsrc1), .PCTarget(tgt1),
    .stall(stall1), .imem(if1), .instr(instr1), .PC(pc1),
    .PCPlus4(p41), .instr_valid(v1), .fetch_fault(ff1),
    .retire_count(rc1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Reference model: expected architectural view after the next edge.
  bit          m_init [2];
  logic [31:0] m_rpc [2];
  logic [31:0] m_pc [2], m_instr [2], m_cnt [2];
  logic        m_valid [2], m_req [2], m_fault [2], m_boot [2];

  int          mem_lat = 1;
  int          mem_cnt [2];
  logic [31:0] mem_a [2];
  logic [31:0] alog0 [$];
  logic [31:0] alog1 [$];

  task automatic compare(input int k, input logic [31:0] pc,
                         input logic [31:0] p4, input logic [31:0] ins,
                         input logic [31:0] rc, input logic v,
                         input logic rq, input logic ff,
                         input logic [31:0] ad);
    if (!m_init[k]) return;
    chk($sformatf("pc[%0d]", k), pc, m_pc[k]);
    chk($sformatf("pcplus4[%0d]", k), p4, m_pc[k] + 32'd4);
    chk($sformatf("instr[%0d]", k), ins, m_instr[k]);
    chk($sformatf("retire[%0d]", k), rc, m_cnt[k]);
    chk($sformatf("valid[%0d]", k), {31'd0, v}, {31'd0, m_valid[k]});
    chk($sformatf("req[%0d]", k), {31'd0, rq}, {31'd0, m_req[k]});
    chk($sformatf("fault[%0d]", k), {31'd0, ff}, {31'd0, m_fault[k]});
    if (m_req[k]) chk($sformatf("addr[%0d]", k), ad, m_pc[k]);
  endtask

  task automatic model_step(input int k, input logic r, input logic st,
                            input logic src, input logic [31:0] tg,
                            input logic rv, input logic rdy);
    logic [31:0] nxt;
    if (r) begin
      m_init[k]  = 1'b1;
      m_pc[k]    = m_rpc[k];
      m_instr[k] = 32'h13;
      m_cnt[k]   = 32'd0;
      m_valid[k] = 1'b0;
      m_req[k]   = 1'b0;
      m_fault[k] = 1'b0;
      m_boot[k]  = 1'b1;
      return;
    end
    if (!m_init[k]) return;
    if (m_boot[k]) begin
      m_boot[k] = 1'b0;
      m_req[k]  = 1'b1;
    end else if (m_req[k]) begin
      if (rdy) m_req[k] = 1'b0;
    end else if (rv) begin
      m_valid[k] = 1'b1;
      m_instr[k] = mem_word(m_pc[k]);
    end else if (m_valid[k] && !st) begin
      m_cnt[k]   = m_cnt[k] + 32'd1;
      m_valid[k] = 1'b0;
      nxt = src ? tg : m_pc[k] + 32'd4;
      if (nxt[1:0] != 2'b00) begin
        m_fault[k] = 1'b1;
      end else begin
        m_pc[k]  = nxt;
        m_req[k] = 1'b1;
      end
    end
  endtask

  task automatic mem_step(input logic r, input logic rq, input logic rdy,
                          input logic [31:0] ad, input int lat,
                          inout int cnt, inout logic [31:0] a,
                          output logic rv);
    rv = 1'b0;
    if (r) begin
      cnt = 0;
      return;
    end
    if (cnt != 0) begin
      cnt--;
      if (cnt == 0) rv = 1'b1;
    end
    if (rq && rdy) begin
      cnt = lat;
      a   = ad;
    end
  endtask

  initial begin
    int          c;
    logic [31:0] a;
    logic        rv;
    forever begin
      @(negedge clk);
      compare(0, pc0, p40, instr0, rc0, v0, if0.imem_req, ff0,
              if0.imem_addr);
      compare(1, pc1, p41, instr1, rc1, v1, if1.imem_req, ff1,
              if1.imem_addr);
      if (!rst && if0.imem_req && if0.imem_ready)
        alog0.push_back(if0.imem_addr);
      if (!rst && if1.imem_req && if1.imem_ready)
        alog1.push_back(if1.imem_addr);
      c = mem_cnt[0]; a = mem_a[0];
      mem_step(rst, if0.imem_req, if0.imem_ready, if0.imem_addr,
               mem_lat, c, a, rv);
      mem_cnt[0] = c; mem_a[0] = a;
      if0.imem_rvalid = rv;
      if0.imem_rdata  = mem_word(a);
      model_step(0, rst, stall0, pcsrc0, tgt0, rv, if0.imem_ready);
      c = mem_cnt[1]; a = mem_a[1];
      mem_step(rst, if1.imem_req, if1.imem_ready, if1.imem_addr,
               1, c, a, rv);
      mem_cnt[1] = c; mem_a[1] = a;
      if1.imem_rvalid = rv;
      if1.imem_rdata  = mem_word(a);
      model_step(1, rst, stall1, pcsrc1, tgt1, rv, if1.imem_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    alog0.delete();
    alog1.delete();
  endtask

  task automatic wait_retire0(input logic [31:0] n, input string nm);
    for (int i = 0; i < 100; i++) begin
      if (rc0 == n) return;
      tick();
    end
    chk({nm, " timeout"}, rc0, n);
  endtask

  task automatic wait_valid0(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (v0) return;
      tick();
    end
    chk({nm, " timeout"}, {31'd0, v0}, 32'd1);
  endtask

  task automatic wait_accept0(input int n, input string nm);
    for (int i = 0; i < 100; i++) begin
      if (alog0.size() >= n) return;
      tick();
    end
    chk({nm, " timeout"}, alog0.size(), n);
  endtask

  initial begin
    int n;
    logic [31:0] seq [4];
    seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    m_rpc[0] = 32'h0;
    m_rpc[1] = RST1;
    rst = 1'b1;
    stall0 = 1'b0; pcsrc0 = 1'b0; tgt0 = 32'h0;
    stall1 = 1'b0; pcsrc1 = 1'b0; tgt1 = 32'h0;
    if0.imem_ready = 1'b1; if0.imem_rvalid = 1'b0; if0.imem_rdata = '0;
    if1.imem_ready = 1'b1; if1.imem_rvalid = 1'b0; if1.imem_rdata = '0;

    // Sequential fetch and reset values
    tick();
    chk("rst pc", pc0, 32'h0);
    chk("rst pcplus4", p40, 32'h4);
    chk("rst instr", instr0, 32'h13);
    chk("rst valid", {31'd0, v0}, 32'd0);
    chk("rst req", {31'd0, if0.imem_req}, 32'd0);
    chk("rst fault", {31'd0, ff0}, 32'd0);
    chk("rst retire", rc0, 32'd0);
    chk("wrap rst pc", pc1, 32'hFFFF_FFFC);
    chk("wrap pcplus4", p41, 32'h0);
    tick();
    rst = 1'b0;
    alog0.delete();
    alog1.delete();
    @(negedge clk);
    chk("boot no req", {31'd0, if0.imem_req}, 32'd0);
    @(negedge clk);
    chk("first req", {31'd0, if0.imem_req}, 32'd1);
    chk("first addr", if0.imem_addr, 32'h0);
    tick();
    wait_retire0(32'd4, "seq retire");
    for (int i = 0; i < 4; i++)
      chk($sformatf("seq addr%0d", i), alog0[i], seq[i]);
    chk("seq retire4", rc0, 32'd4);
    chk("wrap addr0", alog1[0], 32'hFFFF_FFFC);
    chk("wrap addr1", alog1[1], 32'h0);
    chk("wrap nofault", {31'd0, ff1}, 32'd0);

    // Backpressure at PC=8
    do_reset();
    wait_retire0(32'd2, "bp retire");
    if0.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp req held", {31'd0, if0.imem_req}, 32'd1);
      chk("bp addr held", if0.imem_addr, 32'h8);
    end
    if0.imem_ready = 1'b1;
    wait_valid0("bp valid");
    stall0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall valid", {31'd0, v0}, 32'd1);
      chk("stall pc", pc0, 32'h8);
      chk("stall instr", instr0, mem_word(32'h8));
      chk("stall retire", rc0, 32'd2);
      tick();
    end
    stall0 = 1'b0;
    tick();
    chk("bp consume", rc0, 32'd3);
    chk("bp valid drop", {31'd0, v0}, 32'd0);
    tick();
    tick();
    chk("bp one consume", rc0, 32'd3);

    // Branch taken, then target changed under stall
    do_reset();
    wait_retire0(32'd4, "br retire");
    pcsrc0 = 1'b1;
    tgt0 = 32'h40;
    wait_retire0(32'd5, "br consume");
    pcsrc0 = 1'b0;
    wait_accept0(6, "br accept");
    chk("br addr", alog0[5], 32'h40);
    wait_valid0("br valid");
    stall0 = 1'b1;
    pcsrc0 = 1'b1;
    tgt0 = 32'h60;
    tick();
    tick();
    tgt0 = 32'h80;
    tick();
    stall0 = 1'b0;
    tick();
    chk("br2 retire", rc0, 32'd6);
    chk("br2 pc", pc0, 32'h80);
    pcsrc0 = 1'b0;
    wait_accept0(7, "br2 accept");
    chk("br2 addr", alog0[6], 32'h80);

    // Misaligned target
    pcsrc0 = 1'b1;
    tgt0 = 32'h22;
    wait_valid0("mis valid");
    tick();
    chk("mis fault", {31'd0, ff0}, 32'd1);
    chk("mis pc", pc0, 32'h80);
    chk("mis retire", rc0, 32'd7);
    chk("mis valid", {31'd0, v0}, 32'd0);
    n = alog0.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mis no req", {31'd0, if0.imem_req}, 32'd0);
    end
    chk("mis fault sticky", {31'd0, ff0}, 32'd1);
    chk("mis no accept", alog0.size(), n);
    pcsrc0 = 1'b0;

    // Reset in WAIT with a response outstanding
    do_reset();
    chk("rst clears fault", {31'd0, ff0}, 32'd0);
    mem_lat = 100;
    wait_accept0(1, "rw accept");
    chk("rw in wait", {31'd0, if0.imem_req}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rw instr", instr0, 32'h13);
    chk("rw valid", {31'd0, v0}, 32'd0);
    chk("rw pc", pc0, 32'h0);
    chk("rw req", {31'd0, if0.imem_req}, 32'd0);
    rst = 1'b0;
    mem_lat = 1;
    alog0.delete();
    wait_accept0(1, "rw reaccept");
    chk("rw addr", alog0[0], 32'h0);
    wait_valid0("rw valid");
    chk("rw new instr", instr0, mem_word(32'h0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
